// File: rtl/rs232_tx_fifo_pkg.sv
// Shared definitions for the RS-232 blocks: parity codes, FSM states and
// elaboration helpers used by both the TX and the future RX side.
package rs232_tx_fifo_pkg;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_ODD  = 1;
    localparam int unsigned PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_e;

    // Smallest r with 2**r >= v.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'(1) << r) < 64'(v)) r++;
        return r;
    endfunction

    // Bit period in clocks, rounded to nearest.
    function automatic int unsigned bit_ticks(input int unsigned clk_freq,
                                              input int unsigned baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/rs232_tx_fifo_if.sv
// Valid/ready word handshake into the RS-232 transmitter.
interface rs232_tx_fifo_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/rs232_tx_fifo_sync_fifo.sv
// Single-clock FIFO; pointers carry one extra wrap bit to tell full from empty.
module rs232_sync_fifo
    import rs232_tx_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage needs no reset; only the pointers define contents.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/rs232_tx_fifo.sv
// Buffered RS-232 transmitter: words queue in a FIFO and leave LSB-first on tx
// with start bit, optional parity and 1 or 2 stop bits, frames back to back.
module rs232_tx_fifo
    import rs232_tx_fifo_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    rs232_tx_fifo_if.slave bus,
    output logic           tx,
    output logic           busy
);
    localparam int unsigned BIT_TICKS = bit_ticks(CLK_FREQ, BAUD);
    localparam int unsigned CW        = clog2(BIT_TICKS);
    localparam int unsigned BW        = clog2(DATA_BITS);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("rs232_tx_fifo: DATA_BITS must be 5..9");
    end
    if (PARITY > 2) begin : g_bad_parity
        $error("rs232_tx_fifo: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("rs232_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (BIT_TICKS < 2) begin : g_bad_bit_ticks
        $error("rs232_tx_fifo: CLK_FREQ/BAUD gives fewer than 2 clocks per bit");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("rs232_tx_fifo: FIFO_DEPTH must be a power of 2, at least 2");
    end

    state_e               state_q, state_d;
    logic [CW-1:0]        baud_q, baud_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 load;
    logic                 tick_end;
    logic                 push;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_dout;

    function automatic logic parity_of(input logic [DATA_BITS-1:0] w);
        return (PARITY == PARITY_ODD) ? ~(^w) : ^w;
    endfunction

    assign push      = bus.valid && !fifo_full;
    assign bus.ready = !fifo_full;
    assign tick_end  = (baud_q == CW'(BIT_TICKS - 1));
    assign tx        = tx_q;
    assign busy      = busy_q;

    rs232_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (bus.data),
        .pop       (fifo_pop),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Next-state logic; tx_d is the level the line takes after the coming edge.
    always_comb begin
        state_d  = state_q;
        baud_d   = tick_end ? '0 : baud_q + CW'(1);
        bit_d    = bit_q;
        shift_d  = shift_q;
        par_d    = par_q;
        tx_d     = tx_q;
        load     = 1'b0;
        fifo_pop = 1'b0;

        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                tx_d   = 1'b1;
                load   = !fifo_empty;
            end
            S_START: begin
                if (tick_end) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                end
            end
            S_DATA: begin
                if (tick_end) begin
                    if (bit_q == BW'(DATA_BITS - 1)) begin
                        bit_d = '0;
                        if (PARITY != PARITY_NONE) begin
                            state_d = S_PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = S_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d   = bit_q + BW'(1);
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                    end
                end
            end
            S_PARITY: begin
                if (tick_end) begin
                    state_d = S_STOP;
                    bit_d   = '0;
                    tx_d    = 1'b1;
                end
            end
            S_STOP: begin
                if (tick_end) begin
                    if (bit_q == BW'(STOP_BITS - 1)) begin
                        state_d = S_IDLE;
                        load    = !fifo_empty;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // Start a frame: pop into the shifter and drop the line on this edge.
        if (load) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_dout;
            par_d    = parity_of(fifo_dout);
            tx_d     = 1'b0;
            baud_d   = '0;
            state_d  = S_START;
        end

        busy_d = (state_d != S_IDLE) || !fifo_empty;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

endmodule

// File: tb/tb_rs232_tx_fifo.sv
// Scoreboard bench: three transmitter configurations, directed timing checks
// on the default one and randomized traffic on the two fast ones.
module tb_rs232_tx_fifo;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic rst_a, rst_bc;
    logic tx_a, busy_a, tx_b, busy_b, tx_c, busy_c;

    rs232_tx_fifo_if #(.DATA_BITS(8)) bus_a ();
    rs232_tx_fifo_if #(.DATA_BITS(7)) bus_b ();
    rs232_tx_fifo_if #(.DATA_BITS(9)) bus_c ();

    // defaults: 8N1, 434 clocks per bit, depth 4
    rs232_tx_fifo dut_a (.clk(clk), .rst(rst_a), .bus(bus_a), .tx(tx_a), .busy(busy_a));

    // 7 bits, odd parity, 2 stop bits, 12 clocks per bit, depth 2
    rs232_tx_fifo #(.CLK_FREQ(1200), .BAUD(100), .DATA_BITS(7), .PARITY(1),
                    .STOP_BITS(2), .FIFO_DEPTH(2))
        dut_b (.clk(clk), .rst(rst_bc), .bus(bus_b), .tx(tx_b), .busy(busy_b));

    // 9 bits, even parity, 1 stop bit, 1000/60 rounds to 17 clocks per bit, depth 8
    rs232_tx_fifo #(.CLK_FREQ(1000), .BAUD(60), .DATA_BITS(9), .PARITY(2),
                    .STOP_BITS(1), .FIFO_DEPTH(8))
        dut_c (.clk(clk), .rst(rst_bc), .bus(bus_c), .tx(tx_c), .busy(busy_c));

    int          checks   = 0;
    int          failures = 0;
    int unsigned cyc      = 0;
    int unsigned q0[$], q1[$], q2[$];
    bit          abort[3];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int bt_of(input int idx);
        case (idx) 0: return 434; 1: return 12; default: return 17; endcase
    endfunction
    function automatic int db_of(input int idx);
        case (idx) 0: return 8; 1: return 7; default: return 9; endcase
    endfunction
    function automatic int par_of(input int idx);
        case (idx) 0: return 0; 1: return 1; default: return 2; endcase
    endfunction
    function automatic int sb_of(input int idx);
        case (idx) 0: return 1; 1: return 2; default: return 1; endcase
    endfunction
    function automatic int flen_of(input int idx);
        return bt_of(idx) * (1 + db_of(idx) + ((par_of(idx) != 0) ? 1 : 0) + sb_of(idx));
    endfunction

    // Expected line level for frame bit position pos carrying word w.
    function automatic logic exp_bit(input int idx, input int unsigned w, input int pos);
        int ones;
        if (pos == 0) return 1'b0;
        if (pos <= db_of(idx)) return w[pos-1];
        if (par_of(idx) != 0 && pos == db_of(idx) + 1) begin
            ones = $countones(w);
            return (par_of(idx) == 1) ? ((ones % 2) == 0) : ((ones % 2) == 1);
        end
        return 1'b1;
    endfunction

    function automatic logic get_tx(input int idx);
        case (idx) 0: return tx_a; 1: return tx_b; default: return tx_c; endcase
    endfunction
    function automatic logic get_busy(input int idx);
        case (idx) 0: return busy_a; 1: return busy_b; default: return busy_c; endcase
    endfunction
    function automatic logic get_ready(input int idx);
        case (idx) 0: return bus_a.ready; 1: return bus_b.ready; default: return bus_c.ready; endcase
    endfunction

    task automatic drive(input int idx, input int unsigned w, input logic v);
        case (idx)
            0: begin bus_a.data = 8'(w); bus_a.valid = v; end
            1: begin bus_b.data = 7'(w); bus_b.valid = v; end
            default: begin bus_c.data = 9'(w); bus_c.valid = v; end
        endcase
    endtask

    task automatic chk(input bit ok, input string name, input longint got, input longint exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic sb_push(input int idx, input int unsigned w);
        case (idx) 0: q0.push_back(w); 1: q1.push_back(w); default: q2.push_back(w); endcase
    endtask
    task automatic sb_pop(input int idx, output int unsigned w, output bit ok);
        ok = 1'b0;
        w  = 0;
        case (idx)
            0: if (q0.size() > 0) begin w = q0.pop_front(); ok = 1'b1; end
            1: if (q1.size() > 0) begin w = q1.pop_front(); ok = 1'b1; end
            default: if (q2.size() > 0) begin w = q2.pop_front(); ok = 1'b1; end
        endcase
    endtask
    function automatic int sb_size(input int idx);
        case (idx) 0: return q0.size(); 1: return q1.size(); default: return q2.size(); endcase
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push(input int idx, input int unsigned w);
        int guard = 0;
        while (!get_ready(idx) && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        if (!get_ready(idx)) begin
            chk(1'b0, $sformatf("ready timeout dut%0d", idx), 0, 1);
            return;
        end
        drive(idx, w, 1'b1);
        @(posedge clk);
        sb_push(idx, w);
        @(negedge clk);
        drive(idx, w, 1'b0);
    endtask

    task automatic wait_until(input int unsigned t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic wait_idle(input int idx, input int budget);
        int n = 0;
        while (!(sb_size(idx) == 0 && get_busy(idx) == 1'b0 && get_tx(idx) == 1'b1) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(sb_size(idx) == 0 && get_busy(idx) == 1'b0, $sformatf("drain dut%0d", idx),
            sb_size(idx), 0);
    endtask

    // Monitor: on a falling line, pop the expected word and compare every cycle of the frame.
    task automatic mon(input int idx);
        int unsigned w, got;
        bit          ok, aborted;
        int          bad, bt, flen, pos;
        forever begin
            @(negedge clk);
            if (!abort[idx] && get_tx(idx) === 1'b0) begin
                bt   = bt_of(idx);
                flen = flen_of(idx);
                sb_pop(idx, w, ok);
                bad = 0; got = 0; aborted = 1'b0;
                for (int c = 0; c < flen; c++) begin
                    if (c > 0) @(negedge clk);
                    if (abort[idx]) begin aborted = 1'b1; break; end
                    pos = c / bt;
                    if (get_tx(idx) !== exp_bit(idx, w, pos)) bad++;
                    if ((c % bt) == bt / 2 && pos >= 1 && pos <= db_of(idx) && get_tx(idx) === 1'b1)
                        got |= (32'd1 << (pos - 1));
                end
                if (!aborted) begin
                    if (!ok) chk(1'b0, $sformatf("unexpected frame dut%0d", idx), got, -1);
                    else chk(bad == 0, $sformatf("frame dut%0d bad_cycles=%0d", idx, bad), got, w);
                end
            end
        end
    endtask

    task automatic rand_run(input int idx, input int n);
        int          gap;
        int unsigned w;
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            gap = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(0, flen_of(idx));
            repeat (gap) @(negedge clk);
            w = $urandom & ((32'd1 << db_of(idx)) - 1);
            push(idx, w);
        end
        wait_idle(idx, 5000);
    endtask

    task automatic directed_a();
        int unsigned n, s, w;
        int          acc, guard, viol;
        logic        r;

        // single 0x55, 8N1
        @(negedge clk);
        push(0, 8'h55);
        n = cyc;
        chk(tx_a == 1'b1, "t1 tx at accept edge", tx_a, 1);
        chk(busy_a == 1'b0, "t1 busy at accept edge", busy_a, 0);
        @(negedge clk);
        chk(tx_a == 1'b0, "t1 start bit at N+1", tx_a, 0);
        chk(busy_a == 1'b1, "t1 busy at N+1", busy_a, 1);
        wait_until(n + 434);
        chk(tx_a == 1'b0, "t1 last start cycle", tx_a, 0);
        wait_until(n + 435);
        chk(tx_a == 1'b1, "t1 bit0 begins", tx_a, 1);
        wait_until(n + 4340);
        chk(busy_a == 1'b1, "t1 busy in last stop cycle", busy_a, 1);
        wait_until(n + 4341);
        chk(busy_a == 1'b0, "t1 busy falls at N+1+4340", busy_a, 0);
        chk(tx_a == 1'b1, "t1 idle line", tx_a, 1);

        // two 0xFF back to back
        @(negedge clk);
        push(0, 8'hFF);
        n = cyc;
        push(0, 8'hFF);
        wait_until(n + 435);
        chk(tx_a == 1'b1, "t2 data after 434 low", tx_a, 1);
        wait_until(n + 4340);
        chk(tx_a == 1'b1, "t2 end of first frame", tx_a, 1);
        wait_until(n + 4341);
        chk(tx_a == 1'b0, "t2 second start with no gap", tx_a, 0);
        wait_until(n + 8680);
        chk(busy_a == 1'b1, "t2 busy before end", busy_a, 1);
        wait_until(n + 8681);
        chk(tx_a == 1'b1 && busy_a == 1'b0, "t2 line idle after 8680", {tx_a, busy_a}, 2);

        // hold valid with 0x10.. until 6 words taken
        @(negedge clk);
        w = 8'h10; acc = 0; guard = 0;
        while (acc < 6 && guard < 20000) begin
            drive(0, w, 1'b1);
            r = bus_a.ready;
            @(posedge clk);
            if (r) begin
                sb_push(0, w);
                acc++;
                w++;
            end
            @(negedge clk);
            guard++;
            if (r && acc == 5) chk(bus_a.ready == 1'b0, "t4 ready low after 5 accepts", bus_a.ready, 0);
        end
        drive(0, 0, 1'b0);
        chk(acc == 6, "t4 words accepted", acc, 6);
        wait_idle(0, 30000);

        // reset during data bit 3 of 0xA5 with two words queued
        @(negedge clk);
        push(0, 8'hA5);
        s = cyc + 1;
        push(0, 8'h01);
        push(0, 8'h02);
        wait_until(s + 434 * 4 + 200);
        chk(tx_a == 1'b0, "t5 in data bit 3", tx_a, 0);
        abort[0] = 1'b1;
        q0.delete();
        @(negedge clk);
        rst_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_a = 1'b0;
        chk(tx_a == 1'b1, "t5 tx after reset", tx_a, 1);
        chk(busy_a == 1'b0, "t5 busy after reset", busy_a, 0);
        chk(bus_a.ready == 1'b1, "t5 ready after reset", bus_a.ready, 1);
        viol = 0;
        repeat (10000) begin
            @(negedge clk);
            if (tx_a !== 1'b1 || busy_a !== 1'b0) viol++;
        end
        chk(viol == 0, "t5 line stays idle", viol, 0);
        abort[0] = 1'b0;
    endtask

    initial begin
        fork
            mon(0);
            mon(1);
            mon(2);
        join_none
    end

    initial begin
        repeat (98000) @(posedge clk);
        $display("FAIL watchdog: cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        abort[0] = 1'b0; abort[1] = 1'b0; abort[2] = 1'b0;
        rst_a = 1'b1;
        rst_bc = 1'b1;
        drive(0, 0, 1'b0);
        drive(1, 0, 1'b0);
        drive(2, 0, 1'b0);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk(get_tx(i) == 1'b1, $sformatf("reset tx dut%0d", i), get_tx(i), 1);
            chk(get_busy(i) == 1'b0, $sformatf("reset busy dut%0d", i), get_busy(i), 0);
            chk(get_ready(i) == 1'b1, $sformatf("reset ready dut%0d", i), get_ready(i), 1);
        end
        rst_a = 1'b0;
        rst_bc = 1'b0;

        fork
            directed_a();
            rand_run(1, 60);
            rand_run(2, 60);
        join

        for (int i = 0; i < 3; i++)
            chk(sb_size(i) == 0, $sformatf("leftover words dut%0d", i), sb_size(i), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
